// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bus bundle shared by the arbiter's master-facing and slave-facing ports.
// err is an abort indication returned to a bus master; a plain slave leaves it tied low.
interface wb_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ack;
    logic          stall;
    logic          err;

    modport master (output cyc, stb, we, addr, data, input ack, stall, err);
    modport slave  (input cyc, stb, we, addr, data, output ack, stall, err);
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter holding the grant for a whole CYC,
// with a watchdog that aborts transfers the slave never acknowledges.
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    wb_arbiter2_if.slave        m0,
    wb_arbiter2_if.slave        m1,
    wb_arbiter2_if.master       s,
    output logic                o_timeout
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;

    state_t        state, state_nx;
    logic          last_grant, last_grant_nx;
    logic [CW-1:0] wd_cnt, wd_cnt_nx;
    logic          granted;
    logic          cur_cyc;
    logic          oth_cyc;
    logic          abort;

    // The slave's ack on the expiry cycle takes precedence over the abort.
    always_comb begin
        granted = (state == GNT0) || (state == GNT1);
        cur_cyc = (state == GNT1) ? m1.cyc : m0.cyc;
        oth_cyc = (state == GNT1) ? m0.cyc : m1.cyc;
        abort   = granted && (TIMEOUT != 0) && (wd_cnt == CW'(TIMEOUT)) && !s.ack;
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        wd_cnt_nx     = wd_cnt;
        case (state)
            IDLE: begin
                if (m0.cyc && (!m1.cyc || last_grant)) begin
                    state_nx      = GNT0;
                    last_grant_nx = 1'b0;
                    wd_cnt_nx     = '0;
                end else if (m1.cyc) begin
                    state_nx      = GNT1;
                    last_grant_nx = 1'b1;
                    wd_cnt_nx     = '0;
                end
            end
            GNT0, GNT1: begin
                if (abort) begin
                    state_nx = cur_cyc ? DRAIN : IDLE;
                end else if (!cur_cyc) begin
                    if (oth_cyc) begin
                        state_nx      = (state == GNT0) ? GNT1 : GNT0;
                        last_grant_nx = ~last_grant;
                        wd_cnt_nx     = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (s.ack) begin
                    wd_cnt_nx = '0;
                end else if ((TIMEOUT != 0) && (wd_cnt != CW'(TIMEOUT))) begin
                    wd_cnt_nx = wd_cnt + 1'b1;
                end
            end
            DRAIN: begin
                // last_grant still names the master whose transfer was aborted.
                if (!(last_grant ? m1.cyc : m0.cyc)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            wd_cnt     <= wd_cnt_nx;
        end
    end

    // Bus mux and response routing are combinational from state, so reset idles the bus at once.
    always_comb begin
        s.cyc     = 1'b0;
        s.stb     = 1'b0;
        s.we      = 1'b0;
        s.addr    = '0;
        s.data    = '0;
        m0.ack    = 1'b0;
        m0.stall  = 1'b1;
        m0.err    = 1'b0;
        m1.ack    = 1'b0;
        m1.stall  = 1'b1;
        m1.err    = 1'b0;
        o_timeout = abort;
        case (state)
            GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                s.addr   = m0.addr;
                s.data   = m0.data;
                m0.ack   = s.ack;
                m0.stall = s.stall;
                m0.err   = abort;
            end
            GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                s.addr   = m1.addr;
                s.data   = m1.data;
                m1.ack   = s.ack;
                m1.stall = s.stall;
                m1.err   = abort;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed, table-driven bench for wb_arbiter2 with a short watchdog (TIMEOUT=8).
// Each table row is one clock: inputs driven just after posedge, outputs compared at negedge.
module tb_wb_arbiter2;
    logic clk;
    logic reset;
    logic o_timeout;

    wb_arbiter2_if #(.AW(32), .DW(32)) m0_bus ();
    wb_arbiter2_if #(.AW(32), .DW(32)) m1_bus ();
    wb_arbiter2_if #(.AW(32), .DW(32)) s_bus ();

    wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .s         (s_bus),
        .o_timeout (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gnt: 0 = bus idle, 1 = m0 routed to slave, 2 = m1 routed to slave.
    // f:   {m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err, o_timeout}
    typedef struct {
        string      tag;
        logic       m0c, m0w;
        logic [7:0] m0a;
        logic       m1c, m1w;
        logic [7:0] m1a;
        logic       sack, sstall;
        int         gnt;
        logic [6:0] f;
    } vec_t;

    localparam logic [6:0] IDL  = 7'b0100100;
    localparam logic [6:0] G0   = 7'b0000100;
    localparam logic [6:0] G0A  = 7'b1000100;
    localparam logic [6:0] G0S  = 7'b0100100;
    localparam logic [6:0] G0AS = 7'b1100100;
    localparam logic [6:0] G1   = 7'b0100000;
    localparam logic [6:0] G1A  = 7'b0101000;
    localparam logic [6:0] AB0  = 7'b0010101;
    localparam logic [6:0] AB1  = 7'b0100011;

    vec_t vecs[$];
    int   vecCount = 0;
    int   errCount = 0;

    function automatic logic [31:0] m0Addr(input logic [7:0] a); return {24'h000100, a}; endfunction
    function automatic logic [31:0] m0Data(input logic [7:0] a); return {24'hDA0000, a}; endfunction
    function automatic logic [31:0] m1Addr(input logic [7:0] a); return {24'h000200, a}; endfunction
    function automatic logic [31:0] m1Data(input logic [7:0] a); return {24'hDB0000, a}; endfunction

    task automatic addVec(input string tag, input logic m0c, input logic m0w, input logic [7:0] m0a,
                          input logic m1c, input logic m1w, input logic [7:0] m1a,
                          input logic sack, input logic sstall, input int gnt, input logic [6:0] f);
        vec_t v;
        v.tag = tag; v.m0c = m0c; v.m0w = m0w; v.m0a = m0a;
        v.m1c = m1c; v.m1w = m1w; v.m1a = m1a;
        v.sack = sack; v.sstall = sstall; v.gnt = gnt; v.f = f;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        m0_bus.cyc  = v.m0c;
        m0_bus.stb  = v.m0c;
        m0_bus.we   = v.m0w;
        m0_bus.addr = m0Addr(v.m0a);
        m0_bus.data = m0Data(v.m0a);
        m1_bus.cyc  = v.m1c;
        m1_bus.stb  = v.m1c;
        m1_bus.we   = v.m1w;
        m1_bus.addr = m1Addr(v.m1a);
        m1_bus.data = m1Data(v.m1a);
        s_bus.ack   = v.sack;
        s_bus.stall = v.sstall;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [73:0] act;
        logic [73:0] exp;
        logic        ec, ew;
        logic [31:0] ea, ed;
        ec = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        if (v.gnt == 1) begin
            ec = v.m0c; ew = v.m0w; ea = m0Addr(v.m0a); ed = m0Data(v.m0a);
        end else if (v.gnt == 2) begin
            ec = v.m1c; ew = v.m1w; ea = m1Addr(v.m1a); ed = m1Data(v.m1a);
        end
        exp = {ec, ec, ew, ea, ed, v.f};
        act = {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.addr, s_bus.data,
               m0_bus.ack, m0_bus.stall, m0_bus.err, m1_bus.ack, m1_bus.stall, m1_bus.err, o_timeout};
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", v.tag, act, exp);
        end
    endtask

    initial begin
        vec_t r;
        reset = 1'b0;
        s_bus.err = 1'b0;
        r.tag = "reset"; r.m0c = 0; r.m0w = 0; r.m0a = 8'h00; r.m1c = 0; r.m1w = 0; r.m1a = 8'h00;
        r.sack = 0; r.sstall = 0; r.gnt = 0; r.f = IDL;
        applyStimulus(r);

        // Alternation: tie after reset goes to m0, then back-to-back handovers.
        addVec("t2.tie",   1,0,8'h20, 1,1,8'h30, 0,0, 0, IDL);
        addVec("t2.m0ack", 1,0,8'h20, 1,1,8'h30, 1,0, 1, G0A);
        addVec("t2.m0drop",0,0,8'h20, 1,1,8'h30, 0,0, 1, G0);
        addVec("t2.m1ack", 0,0,8'h20, 1,1,8'h30, 1,0, 2, G1A);
        addVec("t2.m1hold",1,0,8'h21, 1,1,8'h31, 0,0, 2, G1);
        addVec("t2.m1drop",1,0,8'h21, 0,1,8'h31, 0,0, 2, G1);
        addVec("t2.m0back",1,0,8'h21, 1,1,8'h32, 1,0, 1, G0A);
        addVec("t2.m0drp2",0,0,8'h21, 1,1,8'h32, 0,0, 1, G0);
        addVec("t2.m1last",0,0,8'h21, 0,1,8'h32, 1,0, 2, G1A);
        addVec("t2.lateack",0,0,8'h00, 0,0,8'h00, 1,0, 0, IDL);
        // m0 alone, slave stalls once then acks.
        addVec("t1.req",   1,0,8'h10, 0,0,8'h00, 0,0, 0, IDL);
        addVec("t1.gnt",   1,0,8'h10, 0,0,8'h00, 0,0, 1, G0);
        addVec("t1.stall", 1,0,8'h10, 0,0,8'h00, 0,1, 1, G0S);
        addVec("t1.ack",   1,0,8'h10, 0,0,8'h00, 1,0, 1, G0A);
        addVec("t1.drop",  0,0,8'h10, 0,0,8'h00, 0,0, 1, G0);
        addVec("t1.idle",  0,0,8'h00, 0,0,8'h00, 0,0, 0, IDL);
        // Tie with last grant m0 goes to m1; then m0 bursts 4 beats while m1 waits.
        addVec("t3.tie",   1,1,8'h40, 1,0,8'h50, 0,0, 0, IDL);
        addVec("t3.m1gnt", 1,1,8'h40, 1,0,8'h50, 0,0, 2, G1);
        addVec("t3.m1end", 1,1,8'h40, 0,0,8'h50, 1,0, 2, G1A);
        addVec("t3.beat1", 1,1,8'h41, 1,0,8'h51, 1,0, 1, G0A);
        addVec("t3.beat2", 1,1,8'h42, 1,0,8'h51, 1,1, 1, G0AS);
        addVec("t3.beat3", 1,1,8'h43, 1,0,8'h51, 1,0, 1, G0A);
        addVec("t3.beat4", 1,1,8'h44, 1,0,8'h51, 1,0, 1, G0A);
        addVec("t3.m0drop",0,0,8'h44, 1,0,8'h51, 0,0, 1, G0);
        addVec("t3.m1gnt2",0,0,8'h00, 1,0,8'h52, 0,0, 2, G1);
        addVec("t3.m1drop",0,0,8'h00, 0,0,8'h52, 0,0, 2, G1);
        addVec("t3.idle",  0,0,8'h00, 0,0,8'h00, 0,0, 0, IDL);
        // Watchdog expiry with m0 still holding CYC, then drain.
        addVec("t4.req",   1,0,8'h60, 0,0,8'h00, 0,0, 0, IDL);
        for (int i = 1; i <= 8; i++)
            addVec($sformatf("t4.wait%0d", i), 1,0,8'h60, 0,0,8'h00, 0,0, 1, G0);
        addVec("t4.abort", 1,0,8'h60, 0,0,8'h00, 0,0, 1, AB0);
        addVec("t4.drain", 1,0,8'h60, 0,0,8'h00, 0,0, 0, IDL);
        addVec("t4.lateack",1,0,8'h60,0,0,8'h00, 1,0, 0, IDL);
        addVec("t4.release",0,0,8'h60,0,0,8'h00, 0,0, 0, IDL);
        addVec("t4.idle",  0,0,8'h00, 0,0,8'h00, 0,0, 0, IDL);
        // Ack exactly on the expiry cycle wins and clears the counter.
        addVec("t5.req",   1,0,8'h70, 0,0,8'h00, 0,0, 0, IDL);
        for (int i = 1; i <= 8; i++)
            addVec($sformatf("t5.wait%0d", i), 1,0,8'h70, 0,0,8'h00, 0,0, 1, G0);
        addVec("t5.ack8",  1,0,8'h70, 0,0,8'h00, 1,0, 1, G0A);
        addVec("t5.after", 1,0,8'h70, 0,0,8'h00, 0,0, 1, G0);
        addVec("t5.drop",  0,0,8'h70, 0,0,8'h00, 0,0, 1, G0);
        addVec("t5.idle",  0,0,8'h00, 0,0,8'h00, 0,0, 0, IDL);
        // m1 drops CYC on the abort cycle: err still pulses, no drain follows.
        addVec("t4b.req",  0,0,8'h00, 1,0,8'h80, 0,0, 0, IDL);
        for (int i = 1; i <= 8; i++)
            addVec($sformatf("t4b.wait%0d", i), 0,0,8'h00, 1,0,8'h80, 0,0, 2, G1);
        addVec("t4b.abort",0,0,8'h00, 0,0,8'h80, 0,0, 2, AB1);
        addVec("t4b.m0req",1,0,8'h90, 0,0,8'h00, 0,0, 0, IDL);
        addVec("t4b.m0gnt",1,0,8'h90, 0,0,8'h00, 0,0, 1, G0);
        addVec("t4b.m0drp",0,0,8'h90, 0,0,8'h00, 0,0, 1, G0);
        addVec("t4b.idle", 0,0,8'h00, 0,0,8'h00, 0,0, 0, IDL);

        #2;
        checkOutput(r);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i]);
        end

        // Reset asserted mid-way through an m1 write must idle the bus without a clock edge.
        r.tag = "t6.req"; r.m0c = 0; r.m0w = 0; r.m0a = 8'h00; r.m1c = 1; r.m1w = 1; r.m1a = 8'h99;
        r.sack = 0; r.sstall = 0; r.gnt = 0; r.f = IDL;
        @(posedge clk); #1; applyStimulus(r); @(negedge clk); checkOutput(r);
        r.tag = "t6.write"; r.gnt = 2; r.f = G1;
        @(posedge clk); #1; applyStimulus(r); @(negedge clk); checkOutput(r);
        #2;
        reset = 1'b0;
        #1;
        r.tag = "t6.asyncrst"; r.gnt = 0; r.f = IDL;
        checkOutput(r);
        r.tag = "t6.inreset"; r.m0c = 1; r.m0a = 8'hA0; r.m1a = 8'hA1;
        @(posedge clk); #1; applyStimulus(r); @(negedge clk); checkOutput(r);
        reset = 1'b1;
        r.tag = "t6.m0first"; r.gnt = 1; r.f = G0;
        @(posedge clk); #1; applyStimulus(r); @(negedge clk); checkOutput(r);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule
